// File: rtl/bist_march_ctrl_if.sv
// SRAM-side bus between the March C- controller and the 256x8 BIST SRAM.
interface bist_march_ctrl_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramin;
    logic              we;
    logic [DATA_W-1:0] ramout;

    // Controller drives address/data/enable and samples read data.
    modport master (output ramaddr, output ramin, output we, input ramout);
    // SRAM side.
    modport slave (input ramaddr, input ramin, input we, output ramout);
endinterface

// File: rtl/bist_march_ctrl.sv
// March C- MBIST controller: {up w0; up r0w1; up r1w0; dn r0w1; dn r1w0; up r0}.
// Reads are issued in phase 0 and checked at the edge closing phase 1, since the
// SRAM registers its read address and returns data one cycle later.
module bist_march_ctrl #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    bist_march_ctrl_if.master       ram,
    output logic                    busy,
    output logic                    done,
    output logic                    fail,
    output logic [ADDR_W-1:0]       fail_addr,
    output logic [2:0]              fail_elem
);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] ADDR_MIN = '0;
    localparam logic [DATA_W-1:0] BG_ONES  = '1;
    localparam logic [DATA_W-1:0] BG_ZERO  = '0;

    typedef enum logic [2:0] {
        S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                phase_q, phase_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                fail_q, fail_d;
    logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
    logic [2:0]          fail_elem_q, fail_elem_d;

    // Per-element attributes: index, direction, expected read and write values.
    logic [2:0]          elem_c;
    logic                desc_c;
    logic [DATA_W-1:0]   exp_c;
    logic [ADDR_W-1:0]   last_c;
    state_t              next_elem_c;
    logic                next_desc_c;

    // Decode element attributes from the current state.
    always_comb begin
        elem_c      = 3'd0;
        desc_c      = 1'b0;
        exp_c       = BG_ZERO;
        next_elem_c = S_DONE;
        next_desc_c = 1'b0;
        case (state_q)
            S_M1: begin elem_c = 3'd1; next_elem_c = S_M2; end
            S_M2: begin elem_c = 3'd2; exp_c = BG_ONES; next_elem_c = S_M3; next_desc_c = 1'b1; end
            S_M3: begin elem_c = 3'd3; desc_c = 1'b1; next_elem_c = S_M4; next_desc_c = 1'b1; end
            S_M4: begin elem_c = 3'd4; desc_c = 1'b1; exp_c = BG_ONES; next_elem_c = S_M5; end
            S_M5: begin elem_c = 3'd5; end
            default: ;
        endcase
        last_c = desc_c ? ADDR_MIN : ADDR_MAX;
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        busy_d      = busy_q;
        done_d      = done_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_M0;
                    phase_d     = 1'b0;
                    addr_d      = ADDR_MIN;
                    wdata_d     = BG_ZERO;
                    we_d        = 1'b1;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    fail_d      = 1'b0;
                    fail_addr_d = ADDR_MIN;
                    fail_elem_d = 3'd0;
                end
            end
            S_M0: begin
                if (addr_q == ADDR_MAX) begin
                    state_d = S_M1;
                    addr_d  = ADDR_MIN;
                    phase_d = 1'b0;
                    we_d    = 1'b0;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            default: begin
                if (!phase_q) begin
                    // Read issued; open the write/check phase at the same address.
                    phase_d = 1'b1;
                    we_d    = (state_q != S_M5);
                    wdata_d = ~exp_c;
                end else begin
                    phase_d = 1'b0;
                    we_d    = 1'b0;
                    if (ram.ramout != exp_c) begin
                        state_d     = S_DONE;
                        fail_d      = 1'b1;
                        fail_addr_d = addr_q;
                        fail_elem_d = elem_c;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end else if (addr_q == last_c) begin
                        if (state_q == S_M5) begin
                            state_d = S_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = next_elem_c;
                            addr_d  = next_desc_c ? ADDR_MAX : ADDR_MIN;
                        end
                    end else begin
                        addr_d = desc_c ? (addr_q - ADDR_W'(1)) : (addr_q + ADDR_W'(1));
                    end
                end
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            phase_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
        end
    end

    assign ram.ramaddr = addr_q;
    assign ram.ramin   = wdata_q;
    assign ram.we      = we_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign fail        = fail_q;
    assign fail_addr   = fail_addr_q;
    assign fail_elem   = fail_elem_q;
endmodule

// File: tb/tb_bist_march_ctrl.sv
// Bench for bist_march_ctrl: behavioural SRAM with injectable stuck-at bits,
// abstract March C- reference model feeding a scoreboard, and a cycle monitor.
module tb_bist_march_ctrl;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;
    localparam int DEPTH = 256;

    typedef struct {
        bit          en;
        logic [7:0]  addr;
        int          bitn;
        bit          val;
        bit [5:0]    mask;   // element indices in which the fault is visible
    } fault_t;

    typedef struct {
        bit          fail;
        logic [7:0]  addr;
        logic [2:0]  elem;
        int          cycles;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, fail;
    logic [7:0] fail_addr;
    logic [2:0] fail_elem;

    int total = 0;
    int bad = 0;

    bist_march_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ram_bus ();

    bist_march_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ram       (ram_bus),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_elem (fail_elem)
    );

    always #5 clk = ~clk;

    // Single-port SRAM with registered read address.
    logic [7:0] mem [DEPTH];
    logic [7:0] addr_reg;
    always @(posedge clk) begin
        addr_reg <= ram_bus.ramaddr;
        if (ram_bus.we) mem[ram_bus.ramaddr] <= ram_bus.ramin;
    end

    // Index of the current busy cycle (0 = first cycle after start is taken).
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)    cyc <= 0;
        else if (busy) cyc <= cyc + 1;
        else           cyc <= 0;
    end

    function automatic int elem_of(int c);
        int e;
        e = (c < DEPTH) ? 0 : 1 + (c - DEPTH) / (2 * DEPTH);
        return (e > 5) ? 5 : e;
    endfunction

    // Read path with fault injection.
    fault_t     fc;
    logic [7:0] rd_c;
    always @* begin
        rd_c = mem[addr_reg];
        if (fc.en && busy && addr_reg == fc.addr && fc.mask[elem_of(cyc)])
            rd_c[fc.bitn] = fc.val;
        ram_bus.ramout = rd_c;
    end

    // Abstract March C- run over an array memory with the same fault model.
    function automatic exp_t model(fault_t f);
        logic [7:0] m [DEPTH];
        exp_t r;
        logic [7:0] rd, expv;
        int a;
        r.fail = 1'b0; r.addr = 8'h00; r.elem = 3'd0; r.cycles = DEPTH * 11;
        for (int i = 0; i < DEPTH; i++) m[i] = 8'h00;
        for (int e = 1; e <= 5; e++) begin
            expv = (e == 2 || e == 4) ? 8'hFF : 8'h00;
            for (int i = 0; i < DEPTH; i++) begin
                a = (e == 3 || e == 4) ? DEPTH - 1 - i : i;
                rd = m[a];
                if (f.en && a == int'(f.addr) && f.mask[e]) rd[f.bitn] = f.val;
                if (rd != expv) begin
                    r.fail = 1'b1;
                    r.addr = 8'(a);
                    r.elem = 3'(e);
                    r.cycles = DEPTH + (e - 1) * 2 * DEPTH + 2 * i + 2;
                    return r;
                end
                if (e != 5) m[a] = ~expv;
            end
        end
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    exp_t sb_q [$];

    // Monitor: per-cycle bus trace while busy, scoreboard pop on each done rise.
    int   busy_cnt = 0;
    bit   prev_done = 1'b0;
    always @(negedge clk) begin : monitor
        int e, off, i;
        logic [7:0] ea, ed;
        bit ew;
        exp_t x;
        if (!rst_n) begin
            busy_cnt = 0;
            prev_done = 1'b0;
        end else begin
            if (busy) begin
                e = elem_of(cyc);
                if (e == 0) begin
                    ea = 8'(cyc); ew = 1'b1; ed = 8'h00;
                end else begin
                    off = cyc - DEPTH - (e - 1) * 2 * DEPTH;
                    i   = off / 2;
                    ea  = (e == 3 || e == 4) ? 8'(DEPTH - 1 - i) : 8'(i);
                    ew  = (off % 2 == 1) && (e != 5);
                    ed  = (e == 1 || e == 3) ? 8'hFF : 8'h00;
                end
                chk("trace_addr", 64'(ram_bus.ramaddr), 64'(ea));
                chk("trace_we", 64'(ram_bus.we), 64'(ew));
                if (ew) chk("trace_wdata", 64'(ram_bus.ramin), 64'(ed));
                busy_cnt++;
            end
            if (done && !prev_done) begin
                if (sb_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got done=1 want no pending run");
                end else begin
                    x = sb_q.pop_front();
                    chk("res_fail", 64'(fail), 64'(x.fail));
                    chk("res_fail_addr", 64'(fail_addr), 64'(x.addr));
                    chk("res_fail_elem", 64'(fail_elem), 64'(x.elem));
                    chk("res_busy_cycles", 64'(busy_cnt), 64'(x.cycles));
                end
                busy_cnt = 0;
            end
            prev_done = done;
        end
    end

    function automatic logic [30:0] out_vec();
        return {busy, done, fail, fail_addr, fail_elem, ram_bus.we, ram_bus.ramaddr, ram_bus.ramin};
    endfunction

    // One complete run: push expectation, pulse start, wait for done, check hold.
    task automatic run_one(fault_t f);
        exp_t x;
        int n, nz;
        @(negedge clk);
        fc = f;
        x = model(f);
        sb_q.push_back(x);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_state", 64'(out_vec()), 64'({1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 8'h00, 8'h00}));
        n = 0;
        while (!done && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL done_timeout: got done=0 want done=1 within 4000 cycles");
            return;
        end
        repeat (3) @(negedge clk);
        chk("done_hold", 64'({done, busy, ram_bus.we, fail, fail_addr, fail_elem}),
            64'({1'b1, 1'b0, 1'b0, x.fail, x.addr, x.elem}));
        if (!f.en) begin
            nz = 0;
            for (int i = 0; i < DEPTH; i++) if (mem[i] !== 8'h00) nz++;
            chk("final_mem_nonzero", 64'(nz), 64'(0));
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        fault_t f;
        fc = '{en: 1'b0, addr: 8'h00, bitn: 0, val: 1'b0, mask: 6'd0};
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", 64'(out_vec()), 64'(0));
        rst_n = 1'b1;

        // Fault-free pass.
        run_one('{en: 1'b0, addr: 8'h00, bitn: 0, val: 1'b0, mask: 6'd0});
        // Stuck-at-1 on bit 0 of 0x5A: caught by the first r0.
        run_one('{en: 1'b1, addr: 8'h5A, bitn: 0, val: 1'b1, mask: 6'h3F});
        // Stuck-at-0 on bit 7 of 0x03: first visible at r1 of element 2.
        run_one('{en: 1'b1, addr: 8'h03, bitn: 7, val: 1'b0, mask: 6'h3F});
        // Fault visible only in descending element 3 at 0xF0.
        run_one('{en: 1'b1, addr: 8'hF0, bitn: $urandom_range(0, 7), val: 1'b1, mask: 6'b001000});

        // Held start mid-run is ignored; async reset at cycle 1000 clears everything.
        @(negedge clk);
        fc = '{en: 1'b0, addr: 8'h00, bitn: 0, val: 1'b0, mask: 6'd0};
        sb_q.push_back(model(fc));
        start = 1'b1;
        repeat (1000) @(negedge clk);
        chk("held_start_cycle", 64'({busy, 32'(cyc)}), 64'({1'b1, 32'd999}));
        #2 rst_n = 1'b0;
        #1 chk("async_reset", 64'(out_vec()), 64'(0));
        start = 1'b0;
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Full pass after reset, then a fail followed by a rerun from DONE.
        run_one('{en: 1'b0, addr: 8'h00, bitn: 0, val: 1'b0, mask: 6'd0});
        run_one('{en: 1'b1, addr: 8'(($urandom_range(0, 255))), bitn: $urandom_range(0, 7), val: 1'b1, mask: 6'h3F});
        for (int k = 0; k < 4; k++) begin
            f.en   = ($urandom_range(0, 3) != 0);
            f.addr = 8'($urandom_range(0, 255));
            f.bitn = $urandom_range(0, 7);
            f.val  = 1'($urandom_range(0, 1));
            f.mask = 6'($urandom_range(1, 63));
            run_one(f);
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
